lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
Serial receiving end of the 4-bit LFSR pseudo-random generator. It consumes the generator's OUT/Valid bit stream and self-synchronises to it. Once synchronised it predicts every subsequent bit, flags and counts bit errors, and declares loss of lock after repeated errors. It is used as the link-integrity monitor for PRBS streams on the bench and in the datapath.

Parameters:
LOCK_CNT, 8, consecutive correct predictions needed in VERIFY to declare lock (1..255)
LOSS_CNT, 3, consecutive mispredictions in LOCKED that drop lock (1..15)
ERR_W, 8, width of the saturating error counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous, active-high reset
IN  input  1  serial data bit from the LFSR generator
Valid  input  1  IN is meaningful this cycle; all state holds when low
Clear  input  1  synchronous clear of Err_Count
Locked  output  1  checker synchronised to the stream
Err_Pulse  output  1  one-cycle pulse on a bit error while LOCKED
Err_Count  output  ERR_W  saturating count of errors while LOCKED
State_Out  output  4  current history register H (recovered generator state)

Behaviour:
- Generator model: state S[3:0], bit emitted = S[0], next S = {S[0]^S[1], S[3:1]}. This is x^4+x+1, period 15, recurrence b(n+4) = b(n) ^ b(n+1).
- History H[3:0] shifts as H' = {bit, H[3:1]}. Predicted next bit P = H[0]^H[1].
- All outputs and H are registered. On RST high, immediately and asynchronously:
  - state = ACQUIRE, H = 0000, fill/run/miss counters = 0
  - Locked = 0, Err_Pulse = 0, Err_Count = 0
- Valid low: no state or counter changes. Err_Pulse = 0.
- FSM (transitions only on Valid-high edges):
  - ACQUIRE: H shifts in IN; fill counter increments. After the 4th valid bit, go to VERIFY.
  - VERIFY: compare IN to P; H shifts in IN (self-sync).
    - Match with H != 0000: run counter +1.
    - Mismatch, or H == 0000: run counter = 0.
    - On the edge where run reaches LOCK_CNT: go to LOCKED, Locked = 1, miss counter = 0.
  - LOCKED: H shifts in P, not IN, so a single corrupted bit does not propagate.
    - Mismatch: Err_Pulse = 1 for one cycle, Err_Count +1 (saturating at all ones), miss counter +1.
    - Match: miss counter = 0.
    - On the edge where miss reaches LOSS_CNT: go to ACQUIRE, Locked = 0, H = 0000, all counters = 0. Err_Count keeps its value.
- Lock latency from reset with an error-free stream: Locked rises on the edge sampling valid bit 4+LOCK_CNT (the 12th with defaults).
- Err_Count:
  - increments only in LOCKED
  - Clear forces 0 and wins over a simultaneous increment
  - Clear does not affect the FSM
- An all-zero stream never locks: the H==0000 guard holds the run counter at 0.
- Err_Pulse is 0 in every state other than LOCKED.
- Counters are sized to hold their parameter value with no wrap.

Test Plan:
- Stream from seed 1001 (1,0,0,1,1,0,1,0,1,1,1,1,0,0,0 repeating) with continuous Valid after RST release -> Locked=1 from the edge sampling bit 12, State_Out tracks the generator, Err_Count=0 over 100 bits.
- Same stream with Valid toggled every other cycle -> lock on the 12th valid bit (24th cycle); H/Err_Count frozen in Valid-low cycles.
- Locked, flip one bit -> one Err_Pulse, Err_Count=1, Locked stays 1, no further pulses on following correct bits.
- Locked, flip 3 consecutive bits -> Err_Count=3, Locked=0 on 3rd error edge. Clean stream after that -> Locked=1 again 12 valid bits later, Err_Count stays 3.
- IN=0, Valid=1 for 60 cycles -> Locked never 1, Err_Count=0. ERR_W=2 with 5 isolated errors while locked -> Err_Count saturates at 3. Clear coincident with an error -> Err_Count=0.
- Assert RST between clock edges while LOCKED -> Locked, Err_Count, State_Out go to 0 immediately (before next edge); reacquire after release.

Source files
------------

// File: rtl/lfsr_checker.sv
// Self-synchronising receiver for the x^4+x+1 PRBS stream: acquires history,
// verifies predictions, then free-runs on its own predictions and counts bit errors.
module lfsr_checker #(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN,
   input  logic             Valid,
   input  logic             Clear,
   output logic             Locked,
   output logic             Err_Pulse,
   output logic [ERR_W-1:0] Err_Count,
   output logic [3:0]       State_Out
);

   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(LOSS_CNT + 1);

   localparam logic [1:0] ACQUIRE  = 2'd0;
   localparam logic [1:0] VERIFY   = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic [1:0]        state;
   logic [3:0]        h;
   logic [1:0]        fill;
   logic [RUN_W-1:0]  run;
   logic [MISS_W-1:0] miss;
   logic              pred;
   logic              mismatch;

   assign pred      = h[0] ^ h[1];
   assign mismatch  = IN != pred;
   assign State_Out = h;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ACQUIRE;
         h         <= 4'b0000;
         fill      <= '0;
         run       <= '0;
         miss      <= '0;
         Locked    <= 1'b0;
         Err_Pulse <= 1'b0;
      end else begin
         Err_Pulse <= 1'b0;
         if (Valid) begin
            case (state)
               ACQUIRE: begin
                  h <= {IN, h[3:1]};
                  if (fill == 2'd3) begin
                     state <= VERIFY;
                     fill  <= '0;
                  end else begin
                     fill <= fill + 1'b1;
                  end
               end
               VERIFY: begin
                  h <= {IN, h[3:1]};
                  // all-zero history is the LFSR lock-up state, never a valid run
                  if (!mismatch && h != 4'b0000) begin
                     if (run == RUN_W'(LOCK_CNT - 1)) begin
                        state  <= S_LOCKED;
                        Locked <= 1'b1;
                        run    <= '0;
                        miss   <= '0;
                     end else begin
                        run <= run + 1'b1;
                     end
                  end else begin
                     run <= '0;
                  end
               end
               S_LOCKED: begin
                  // free-run on our own prediction so a corrupted bit cannot poison h
                  if (mismatch) begin
                     Err_Pulse <= 1'b1;
                     if (miss == MISS_W'(LOSS_CNT - 1)) begin
                        state  <= ACQUIRE;
                        Locked <= 1'b0;
                        h      <= 4'b0000;
                        miss   <= '0;
                        run    <= '0;
                        fill   <= '0;
                     end else begin
                        miss <= miss + 1'b1;
                        h    <= {pred, h[3:1]};
                     end
                  end else begin
                     miss <= '0;
                     h    <= {pred, h[3:1]};
                  end
               end
               default: state <= ACQUIRE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         Err_Count <= '0;
      else if (Clear)
         Err_Count <= '0;
      else if (Valid && state == S_LOCKED && mismatch && Err_Count != '1)
         Err_Count <= Err_Count + 1'b1;
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised scoreboard bench for lfsr_checker: a bit-history model predicts outputs,
// a monitor compares two instances (8-bit and 2-bit error counters) every clock.
module tb_lfsr_checker;

   localparam int LOCK = 8;
   localparam int LOSS = 3;

   logic       CLK = 1'b0, RST = 1'b0, IN = 1'b0, Valid = 1'b0, Clear = 1'b0;
   logic       lk8, ep8, lk2, ep2;
   logic [7:0] ec8;
   logic [1:0] ec2;
   logic [3:0] so8, so2;

   lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(8)) dut8 (
      .CLK(CLK), .RST(RST), .IN(IN), .Valid(Valid), .Clear(Clear),
      .Locked(lk8), .Err_Pulse(ep8), .Err_Count(ec8), .State_Out(so8));

   lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(2)) dut2 (
      .CLK(CLK), .RST(RST), .IN(IN), .Valid(Valid), .Clear(Clear),
      .Locked(lk2), .Err_Pulse(ep2), .Err_Count(ec2), .State_Out(so2));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       locked;
      logic       pulse;
      logic [7:0] c8;
      logic [1:0] c2;
      logic [3:0] h;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_fail = 0;

   // reference model: last four received/predicted bits, oldest at the front
   int m_mode, m_fill, m_run, m_miss, m_err;
   bit m_pulse;
   bit m_hist[$];
   int seq_bits[15] = '{1,0,0,1,1,0,1,0,1,1,1,1,0,0,0};
   int gidx;

   task automatic check(string name, logic [7:0] act, logic [7:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
      end
   endtask

   function automatic void m_reset();
      m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
      m_hist = '{0, 0, 0, 0};
   endfunction

   function automatic void m_shift(bit b);
      void'(m_hist.pop_front());
      m_hist.push_back(b);
   endfunction

   function automatic void m_step(bit in, bit v, bit clr);
      bit pred, zero;
      m_pulse = 0;
      if (v) begin
         pred = m_hist[0] ^ m_hist[1];
         zero = !(m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3]);
         if (m_mode == 0) begin
            m_shift(in);
            m_fill++;
            if (m_fill == 4) begin m_mode = 1; m_fill = 0; end
         end else if (m_mode == 1) begin
            m_shift(in);
            m_run = (in == pred && !zero) ? m_run + 1 : 0;
            if (m_run == LOCK) begin m_mode = 2; m_run = 0; m_miss = 0; end
         end else begin
            if (in != pred) begin
               m_pulse = 1;
               m_err++;
               m_miss++;
               if (m_miss == LOSS) begin
                  m_mode = 0; m_miss = 0; m_run = 0; m_fill = 0;
                  m_hist = '{0, 0, 0, 0};
               end else m_shift(pred);
            end else begin
               m_miss = 0;
               m_shift(pred);
            end
         end
      end
      if (clr) m_err = 0;
   endfunction

   function automatic exp_t m_snap();
      exp_t e;
      e.locked = (m_mode == 2);
      e.pulse  = m_pulse;
      e.c8     = (m_err > 255) ? 8'hff : 8'(m_err);
      e.c2     = (m_err > 3) ? 2'd3 : 2'(m_err);
      e.h      = {m_hist[3], m_hist[2], m_hist[1], m_hist[0]};
      return e;
   endfunction

   function automatic bit next_bit();
      bit b = bit'(seq_bits[gidx]);
      gidx = (gidx + 1) % 15;
      return b;
   endfunction

   task automatic step(bit in, bit v, bit clr);
      @(negedge CLK);
      IN = in; Valid = v; Clear = clr;
      m_step(in, v, clr);
      sb.push_back(m_snap());
   endtask

   task automatic send_clean(int n, bit toggle);
      for (int i = 0; i < n; i++) begin
         if (toggle && (i % 2 == 1)) step(bit'($urandom), 1'b0, 1'b0);
         else step(next_bit(), 1'b1, 1'b0);
      end
   endtask

   task automatic send_flip(bit clr);
      step(~next_bit(), 1'b1, clr);
   endtask

   // reset lands between edges; outputs must clear before any further clock
   task automatic do_reset();
      @(posedge CLK);
      #3;
      RST = 1'b1; Valid = 1'b0; Clear = 1'b0;
      #1;
      check("rst_locked", {7'd0, lk8}, 8'd0);
      check("rst_pulse", {7'd0, ep8}, 8'd0);
      check("rst_count8", ec8, 8'd0);
      check("rst_count2", {6'd0, ec2}, 8'd0);
      check("rst_state", {4'd0, so8}, 8'd0);
      m_reset();
      gidx = 0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("locked", {7'd0, lk8}, {7'd0, e.locked});
            check("err_pulse", {7'd0, ep8}, {7'd0, e.pulse});
            check("err_count8", ec8, e.c8);
            check("state_out", {4'd0, so8}, {4'd0, e.h});
            check("err_count2", {6'd0, ec2}, {6'd0, e.c2});
            check("locked_w2", {7'd0, lk2}, {7'd0, e.locked});
         end
      end
   end

   initial begin : stimulus
      bit v, b, clr;
      m_reset();
      gidx = 0;
      do_reset();

      // clean stream: lock exactly on the 12th bit
      send_clean(11, 1'b0);
      @(posedge CLK); #2;
      check("lock_before_12", {7'd0, lk8}, 8'd0);
      send_clean(1, 1'b0);
      @(posedge CLK); #2;
      check("lock_at_12", {7'd0, lk8}, 8'd1);
      send_clean(88, 1'b0);

      // isolated errors, saturating the 2-bit counter
      send_flip(1'b0);
      send_clean(20, 1'b0);
      for (int i = 0; i < 4; i++) begin
         send_flip(1'b0);
         send_clean(6, 1'b0);
      end
      // clear wins over a coincident error
      send_flip(1'b1);
      send_clean(5, 1'b0);
      // three consecutive errors drop lock, then relock
      for (int i = 0; i < 3; i++) send_flip(1'b0);
      send_clean(30, 1'b0);

      // reset while locked, reacquire
      do_reset();
      send_clean(20, 1'b0);

      // valid every other cycle
      do_reset();
      send_clean(60, 1'b1);

      // all-zero stream never locks
      do_reset();
      for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0);

      // random valid, errors and clears
      do_reset();
      for (int i = 0; i < 800; i++) begin
         v   = ($urandom % 4) != 0;
         b   = v ? next_bit() : bit'($urandom);
         if (v && ($urandom % 25) == 0) b = ~b;
         clr = ($urandom % 40) == 0;
         step(b, v, clr);
      end
      @(negedge CLK);
      Valid = 1'b0; Clear = 1'b0;

      for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge CLK);
      #3;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected responses never compared, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
